shift_rows_pipe: RTL

Pipelined, parametrised AES ShiftRows/InvShiftRows unit for the vector ALU, handling LANES independent 128-bit AES states per beat. Direction is chosen per transaction: forward, inverse or bypass. Valid/ready handshake on both sides, full throughput, STAGES-cycle latency, plus a synchronous flush. An opaque tag travels with each beat so the issue logic can match results to requests.

---
 rtl/shift_rows_pipe_pkg.sv | 25 ++
 rtl/shift_rows_pipe_if.sv | 36 +++
 rtl/shift_rows_pipe_core.sv | 31 +++
 rtl/shift_rows_pipe.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/shift_rows_pipe_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES types for the ShiftRows pipeline: the 128-bit state type, the
// per-transaction direction encoding and the byte-index helper that maps a
// (row, column) position onto the FIPS-197 column-major byte order.
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  // 2'b11 is not listed; decoders treat every non-FWD/INV code as bypass.
  typedef enum logic [1:0] {
    SR_FWD = 2'b00,
    SR_INV = 2'b01,
    SR_BYP = 2'b10
  } sr_mode_e;

  localparam int unsigned AES_BYTES = 16;

  // Byte i sits at row i%4, column i/4, so the inverse map is 4*c + r.
  function automatic int unsigned sr_byte_idx(input int unsigned r, input int unsigned c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// -----------------------------------------------------------------------------
// shift_rows_pipe_if
// Valid/ready bus of the ShiftRows pipeline, input side and output side.
//   in_valid/in_ready  : input handshake
//   in_mode            : 00 forward, 01 inverse, 10/11 bypass
//   in_tag/out_tag     : opaque sideband returned with the result
//   in_state/out_state : LANES x 128-bit AES states, lane k at [128k+127:128k]
//   out_valid/out_ready: output handshake
// master = issuing/consuming logic, slave = the pipeline itself.
// -----------------------------------------------------------------------------
interface shift_rows_pipe_if #(
  parameter int LANES = 1,
  parameter int TAG_W = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_mode;
  logic [TAG_W-1:0]       in_tag;
  logic [128*LANES-1:0]   in_state;
  logic                   out_valid;
  logic                   out_ready;
  logic [TAG_W-1:0]       out_tag;
  logic [128*LANES-1:0]   out_state;

  modport master (
    output in_valid, in_mode, in_tag, in_state, out_ready,
    input  in_ready, out_valid, out_tag, out_state
  );

  modport slave (
    input  in_valid, in_mode, in_tag, in_state, out_ready,
    output in_ready, out_valid, out_tag, out_state
  );

endinterface

// File: rtl/shift_rows_pipe_core.sv
// -----------------------------------------------------------------------------
// shift_rows_core
// Combinational ShiftRows / InvShiftRows / bypass on one 128-bit AES state.
//   state_in  : input state (byte i = bits [127-8i -: 8])
//   mode      : 00 forward, 01 inverse, 10/11 bypass
//   state_out : transformed state
// Every output byte is a fixed 3:1 mux; the source byte positions are
// elaboration-time constants, so no shifter logic is built.
// -----------------------------------------------------------------------------
module shift_rows_core
  import aes_pkg::*;
(
  input  aes_state_t state_in,
  input  logic [1:0] mode,
  output aes_state_t state_out
);

  for (genvar gi = 0; gi < AES_BYTES; gi++) begin : gen_byte
    localparam int unsigned ROW     = gi % 4;
    localparam int unsigned COL     = gi / 4;
    // Forward: row r rotates left by r. Inverse: row r rotates right by r.
    localparam int unsigned FWD_SRC = sr_byte_idx(ROW, (COL + ROW) % 4);
    localparam int unsigned INV_SRC = sr_byte_idx(ROW, (COL + 4 - ROW) % 4);

    assign state_out[127-8*gi -: 8] =
        (mode == SR_FWD) ? state_in[127-8*FWD_SRC -: 8] :
        (mode == SR_INV) ? state_in[127-8*INV_SRC -: 8] :
                           state_in[127-8*gi -: 8];
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// shift_rows_pipe
// Elastic STAGES-deep pipeline around LANES copies of shift_rows_core.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   flush    : synchronous clear of all in-flight beats (highest priority)
//   bus      : valid/ready in/out bus (slave side)
//   busy     : some stage holds a valid beat
//   inflight : number of valid beats held (0..STAGES)
// The transform happens before the first register, so the stages only carry
// the result and its tag. Each stage moves when it is empty or when the stage
// after it moves; the ready chain is purely combinational from out_ready.
// -----------------------------------------------------------------------------
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  shift_rows_pipe_if.slave             bus,
  output logic                         busy,
  output logic [$clog2(STAGES+1)-1:0]  inflight
);

  localparam int W  = 128 * LANES;
  localparam int CW = $clog2(STAGES + 1);

  logic [W-1:0]      xform;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [W-1:0]      stage_data [STAGES];
  logic [TAG_W-1:0]  stage_tag  [STAGES];
  logic              accept;
  logic              deliver;
  logic [CW-1:0]     cnt_reg;

  for (genvar gi = 0; gi < LANES; gi++) begin : gen_lane
    shift_rows_core u_core (
      .state_in  (bus.in_state[128*gi +: 128]),
      .mode      (bus.in_mode),
      .state_out (xform[128*gi +: 128])
    );
  end

  // Walk from the output back to the input so each stage sees whether the
  // next one frees up this cycle.
  always_comb begin : adv_chain
    logic carry;
    adv   = '0;
    carry = bus.out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      adv[s] = !v[s] || carry;
      carry  = adv[s];
    end
  end

  assign bus.in_ready = !flush && adv[0];
  assign accept       = bus.in_valid && bus.in_ready;
  assign deliver      = v[STAGES-1] && bus.out_ready && !flush;

  for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
    logic             v_reg;
    logic [W-1:0]     data_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             up_valid;
    logic [W-1:0]     up_data;
    logic [TAG_W-1:0] up_tag;

    if (gi == 0) begin : gen_head
      assign up_valid = accept;
      assign up_data  = xform;
      assign up_tag   = bus.in_tag;
    end else begin : gen_body
      assign up_valid = v[gi-1];
      assign up_data  = stage_data[gi-1];
      assign up_tag   = stage_tag[gi-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_reg <= 1'b0;
      end else if (flush) begin
        v_reg <= 1'b0;
      end else if (adv[gi]) begin
        v_reg <= up_valid;
      end
    end

    // Only the output stage is visible, so only it gets a data reset.
    if (gi == STAGES - 1) begin : gen_out_data
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
          tag_reg  <= '0;
        end else if (adv[gi] && up_valid) begin
          data_reg <= up_data;
          tag_reg  <= up_tag;
        end
      end
    end else begin : gen_mid_data
      always_ff @(posedge clk) begin
        if (adv[gi] && up_valid) begin
          data_reg <= up_data;
          tag_reg  <= up_tag;
        end
      end
    end

    assign v[gi]          = v_reg;
    assign stage_data[gi] = data_reg;
    assign stage_tag[gi]  = tag_reg;
  end

  assign bus.out_valid = v[STAGES-1];
  assign bus.out_state = stage_data[STAGES-1];
  assign bus.out_tag   = stage_tag[STAGES-1];

  // Accept and deliver in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (flush) begin
      cnt_reg <= '0;
    end else begin
      case ({accept, deliver})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  assign inflight = cnt_reg;
  assign busy     = (cnt_reg != '0);

endmodule
